// File: rtl/mem_access_pkg.sv
// Shared types and lane helpers for the core-to-RAM access controller.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPTURE,
    RMW_MERGE,
    WRITE,
    RESP
  } state_e;

  function automatic logic [31:0] lane_extract(
    input logic [31:0] w,
    input logic [1:0]  off,
    input logic [1:0]  size,
    input logic        uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (size)
      SZ_BYTE: r = {{24{b[7] & ~uns}}, b};
      SZ_HALF: r = {{16{h[15] & ~uns}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [1:0]  off,
    input logic [1:0]  size
  );
    logic [31:0] r;
    r = old;
    case (size)
      SZ_BYTE: r[{off, 3'b000} +: 8] = wd[7:0];
      SZ_HALF: begin
        if (off[1]) r[31:16] = wd[15:0];
        else        r[15:0]  = wd[15:0];
      end
      default: r = wd;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_lane.sv
// Combinational lane unit: load extract/extend and sub-word store merge.
module mem_lane_unit
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] ext_o,
  output logic [31:0] merged_o
);

  assign ext_o    = lane_extract(rdata_i, off_i, size_i, uns_i);
  assign merged_o = lane_merge(rdata_i, wdata_i, off_i, size_i);

endmodule

// File: rtl/mem_access_ctrl.sv
// Core load/store to single-port RAM controller with RMW for sub-word stores.
// Define MEM_ACCESS_ERR_CHECK_EN to reject misaligned/out-of-range requests.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_r_wn,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data_in,
  input  logic [31:0]       mem_data_out
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_e state_q, state_d;

  logic              we_q, uns_q;
  logic [1:0]        size_q, off_q;
  logic [31:0]       wdata_q;
  logic              r_wn_q, r_wn_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [1:0]  size_n, off_n;
  logic        req_err, accept;
  logic        idx_oor, hi_nz;
  logic [31:0] ext, merged;

  assign accept  = req_valid && (state_q == IDLE);
  assign idx_oor = {1'b0, req_addr[ADDR_W+1:2]} >= DEPTH_L;
  assign hi_nz   = |req_addr[31:ADDR_W+2];

`ifdef MEM_ACCESS_ERR_CHECK_EN
  always_comb begin
    size_n  = req_size;
    off_n   = req_addr[1:0];
    req_err = idx_oor | hi_nz;
    case (req_size)
      SZ_HALF: req_err = req_err | req_addr[0];
      SZ_WORD: req_err = req_err | (|req_addr[1:0]);
      SZ_RSVD: req_err = 1'b1;
      default: ;
    endcase
  end
`else
  logic unused_chk;
  assign unused_chk = idx_oor ^ hi_nz;

  // Low address bits below the access size are simply dropped.
  always_comb begin
    size_n  = (req_size == SZ_RSVD) ? SZ_WORD : req_size;
    req_err = 1'b0;
    case (size_n)
      SZ_BYTE: off_n = req_addr[1:0];
      SZ_HALF: off_n = {req_addr[1], 1'b0};
      default: off_n = 2'b00;
    endcase
  end
`endif

  mem_lane_unit u_lane (
    .rdata_i  (mem_data_out),
    .wdata_i  (wdata_q),
    .off_i    (off_q),
    .size_i   (size_q),
    .uns_i    (uns_q),
    .ext_o    (ext),
    .merged_o (merged)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    r_wn_d  = 1'b1;
    din_d   = din_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = req_addr[ADDR_W+1:2];
          rdata_d = '0;
          err_d   = 1'b0;
          if (req_err) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else if (req_we && size_n == SZ_WORD) begin
            state_d = WRITE;
            r_wn_d  = 1'b0;
            din_d   = req_wdata;
          end else begin
            state_d = RD_ISSUE;
          end
        end
      end
      RD_ISSUE:   state_d = we_q ? RMW_MERGE : RD_CAPTURE;
      RD_CAPTURE: begin
        rdata_d = ext;
        state_d = RESP;
      end
      RMW_MERGE: begin
        din_d   = merged;
        r_wn_d  = 1'b0;
        state_d = WRITE;
      end
      WRITE: state_d = RESP;
      RESP:  if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_wn_q  <= 1'b1;
      addr_q  <= '0;
      din_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_wn_q  <= r_wn_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_WORD;
      off_q   <= 2'b00;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      uns_q   <= req_unsigned;
      size_q  <= size_n;
      off_q   <= off_n;
      wdata_q <= req_wdata;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = (state_q == RESP);
  assign resp_rdata  = rdata_q;
  assign resp_err    = err_q;
  assign mem_r_wn    = r_wn_q;
  assign mem_address = addr_q;
  assign mem_data_in = din_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a behavioural single-port RAM.
module tb_mem_access_ctrl;
  import mem_access_pkg::*;

  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]        req_size;
  logic [31:0]       req_addr, req_wdata;
  logic              resp_valid, resp_ready, resp_err;
  logic [31:0]       resp_rdata;
  logic              mem_r_wn;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_data_in, mem_data_out;

  mem_access_ctrl #(.ADDR_W(ADDR_W), .DEPTH(1024)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_r_wn     (mem_r_wn),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [0:4095];
  int wr_cnt = 0;

  always @(posedge clk) begin
    if (!mem_r_wn) begin
      ram[mem_address] <= mem_data_in;
      wr_cnt <= wr_cnt + 1;
    end else begin
      mem_data_out <= ram[mem_address];
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wr;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_req(
    string tag, logic we, logic [1:0] sz, logic uns,
    logic [31:0] a, logic [31:0] wd,
    logic [31:0] er, logic ee, int el, int ew, int hold
  );
    exp_t e;
    int lat;
    int w0;
    sb.push_back('{er, ee, el, ew});
    @(negedge clk);
    chk({tag, "/ready"}, 32'(req_ready), 32'd1);
    w0 = wr_cnt;
    req_valid = 1'b1;
    req_we = we;
    req_size = sz;
    req_unsigned = uns;
    req_addr = a;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    e = sb.pop_front();
    chk({tag, "/lat"}, 32'(lat), 32'(e.lat));
    chk({tag, "/rdata"}, resp_rdata, e.rdata);
    chk({tag, "/err"}, 32'(resp_err), 32'(e.err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "/hold_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, "/hold_ready"}, 32'(req_ready), 32'd0);
      chk({tag, "/hold_rdata"}, resp_rdata, e.rdata);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk({tag, "/idle"}, 32'(req_ready), 32'd1);
    chk({tag, "/valid_low"}, 32'(resp_valid), 32'd0);
    chk({tag, "/writes"}, 32'(wr_cnt - w0), 32'(e.wr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w0;
    rst_n = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = SZ_WORD;
    req_unsigned = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    resp_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst/req_ready", 32'(req_ready), 32'd1);
    chk("rst/resp_valid", 32'(resp_valid), 32'd0);
    chk("rst/r_wn", 32'(mem_r_wn), 32'd1);
    chk("rst/addr", 32'(mem_address), 32'd0);
    chk("rst/din", mem_data_in, 32'd0);
    chk("rst/rdata", resp_rdata, 32'd0);
    chk("rst/err", 32'(resp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_req("st_w5", 1, SZ_WORD, 0, 32'h14, 32'h8899AABB, 0, 0, 2, 1, 0);
    chk("ram5_a", ram[5], 32'h8899AABB);
    do_req("ld_bs", 0, SZ_BYTE, 0, 32'h16, 0, 32'hFFFFFF99, 0, 3, 0, 0);
    do_req("ld_bu", 0, SZ_BYTE, 1, 32'h15, 0, 32'h000000AA, 0, 3, 0, 0);
    do_req("ld_hs", 0, SZ_HALF, 0, 32'h16, 0, 32'hFFFF8899, 0, 3, 0, 0);
    do_req("ld_hu", 0, SZ_HALF, 1, 32'h14, 0, 32'h0000AABB, 0, 3, 0, 0);
    do_req("ld_w", 0, SZ_WORD, 0, 32'h14, 0, 32'h8899AABB, 0, 3, 0, 0);
    do_req("st_h", 1, SZ_HALF, 0, 32'h16, 32'h00001234, 0, 0, 4, 1, 0);
    chk("ram5_b", ram[5], 32'h1234AABB);
    do_req("st_b", 1, SZ_BYTE, 0, 32'h15, 32'hFFFFFF5A, 0, 0, 4, 1, 0);
    chk("ram5_c", ram[5], 32'h12345ABB);
    do_req("st_w0", 1, SZ_WORD, 0, 32'h0, 32'hDEADBEEF, 0, 0, 2, 1, 5);
    do_req("ld_w0", 0, SZ_WORD, 0, 32'h0, 0, 32'hDEADBEEF, 0, 3, 0, 0);

`ifdef MEM_ACCESS_ERR_CHECK_EN
    do_req("st_mis", 1, SZ_WORD, 0, 32'h2, 32'h11223344, 0, 1, 1, 0, 0);
    chk("ram0_mis", ram[0], 32'hDEADBEEF);
    do_req("st_oor", 1, SZ_WORD, 0, 32'h1000, 32'hCAFEF00D, 0, 1, 1, 0, 0);
    do_req("ld_hmis", 0, SZ_HALF, 1, 32'h17, 0, 0, 1, 1, 0, 0);
    do_req("ld_rsvd", 0, SZ_RSVD, 0, 32'h14, 0, 0, 1, 1, 0, 0);
    do_req("ld_hi", 0, SZ_WORD, 0, 32'h80000014, 0, 0, 1, 1, 0, 0);
    do_req("st_hmis", 1, SZ_HALF, 0, 32'h15, 32'h0000FFFF, 0, 1, 1, 0, 0);
    chk("ram5_hmis", ram[5], 32'h12345ABB);
`else
    do_req("st_mis", 1, SZ_WORD, 0, 32'h2, 32'h11223344, 0, 0, 2, 1, 0);
    chk("ram0_mis", ram[0], 32'h11223344);
    do_req("st_oor", 1, SZ_WORD, 0, 32'h1000, 32'hCAFEF00D, 0, 0, 2, 1, 0);
    chk("ram1024", ram[1024], 32'hCAFEF00D);
    do_req("ld_hmis", 0, SZ_HALF, 1, 32'h17, 0, 32'h00001234, 0, 3, 0, 0);
    do_req("ld_rsvd", 0, SZ_RSVD, 0, 32'h14, 0, 32'h12345ABB, 0, 3, 0, 0);
    do_req("ld_hi", 0, SZ_WORD, 0, 32'h80000014, 0, 32'h12345ABB, 0, 3, 0, 0);
`endif

    // Abort an RMW in its WRITE cycle.
    @(negedge clk);
    w0 = wr_cnt;
    req_valid = 1'b1;
    req_we = 1'b1;
    req_size = SZ_BYTE;
    req_unsigned = 1'b0;
    req_addr = 32'h14;
    req_wdata = 32'h00000077;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("abort/in_write", 32'(mem_r_wn), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort/r_wn", 32'(mem_r_wn), 32'd1);
    chk("abort/valid", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("abort/ram5", ram[5], 32'h12345ABB);
    chk("abort/writes", 32'(wr_cnt - w0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort/ready", 32'(req_ready), 32'd1);
    chk("abort/valid2", 32'(resp_valid), 32'd0);
    do_req("ld_after", 0, SZ_WORD, 0, 32'h14, 0, 32'h12345ABB, 0, 3, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator side of the shared single-port instruction/data RAM (clk, r_wn, 12-bit word address, 32-bit data_in/data_out).
- Accepts byte, half and word load/store requests from the RISC-V core over a valid/ready handshake and drives the RAM port.
- Performs read-modify-write for sub-word stores, because the RAM writes whole words only.
- Returns sign- or zero-extended load data, or a store acknowledge, over a valid/ready response channel.

Parameters:
ADDR_W, 12, RAM word-address width (mem_address width)
DEPTH, 1024, number of implemented RAM words; word index >= DEPTH is out of range

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  core request valid
req_ready  output  1  controller can accept a request (high only in IDLE)
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  output  1  response valid
resp_ready  input  1  core accepts the response
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  request rejected, no RAM write performed
mem_r_wn  output  1  to RAM r_wn: 1 read, 0 write
mem_address  output  ADDR_W  to RAM address, word index = req_addr[ADDR_W+1:2]
mem_data_in  output  32  to RAM data_in
mem_data_out  input  32  from RAM data_out, valid the cycle after a read edge

Behaviour:
- Reset (async, rst_n low): state IDLE, mem_r_wn=1, mem_address=0, mem_data_in=0, resp_valid=0, resp_rdata=0, resp_err=0. Asserting mid-operation aborts immediately. mem_r_wn drops to 1 at once, so no RAM write occurs at the next edge. No response is produced for the aborted request.
- All RAM-side outputs are registered. mem_r_wn=1 in every state except WRITE.
- States: IDLE, RD_ISSUE, RD_CAPTURE, RMW_MERGE, WRITE, RESP.
- Acceptance happens at the edge where req_valid & req_ready are both high (cycle T). The request is registered at that edge.
- Load: RD_ISSUE (T+1, address driven) -> RD_CAPTURE (T+2, mem_data_out sampled, lane selected by addr[1:0], then extended) -> RESP. resp_valid rises in T+3.
- Word store: WRITE (T+1, mem_r_wn=0, mem_data_in=req_wdata) -> RESP. resp_valid rises in T+2.
- Sub-word store: RD_ISSUE (T+1) -> RMW_MERGE (T+2, the addressed byte/half lanes of mem_data_out are replaced by req_wdata) -> WRITE (T+3) -> RESP. resp_valid rises in T+4.
- RESP: resp_valid, resp_rdata and resp_err are held stable until resp_ready is high. The state returns to IDLE on that edge.
- req_ready is high only in IDLE, so a new request is never accepted in the same edge as a response handshake (no back-to-back overlap).
- Error (see optional feature): go directly to RESP with resp_err=1 and rdata=0. resp_valid rises in T+1. The RAM is never written.
- Byte lane: addr[1:0]=n selects bits [8n+7:8n]. Half uses addr[1] (bits [15:0] or [31:16]).

Optional Feature:
MEM_ACCESS_ERR_CHECK_EN
- Defined: the following give an error response:
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - req_size=11
  - word index >= DEPTH
  - any addr bits above ADDR_W+1 nonzero
- Undefined: addresses are forced aligned (low bits ignored per size), size 11 is treated as word, high bits are ignored, and resp_err is tied 0.

Decomposition:
- Package mem_access_pkg holds the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the state enum, and the functions lane_extract (select plus extend) and lane_merge.
- One natural sub-module: mem_lane_unit, combinational extract/extend and merge. It is shared by the load path and the RMW path.

Test Plan:
- Preload word 5 = 0x8899AABB; load byte signed at addr 0x16 -> resp_rdata=0xFFFFFF99, err=0, resp_valid 3 cycles after acceptance.
- Half store 0x1234 at addr 0x16 over 0x8899AABB -> RAM word 5 = 0x1234AABB; exactly one write cycle; resp at T+4.
- Word store 0xDEADBEEF to addr 0x0 with resp_ready held low 5 cycles -> resp_valid held, req_ready low throughout; after release, load word 0 returns 0xDEADBEEF.
- With MEM_ACCESS_ERR_CHECK_EN: word store to 0x2 -> resp_err=1 at T+1, RAM unchanged. Without it: same request writes word 0.
- Word index 1024 (addr 0x1000) with the check enabled -> resp_err=1, no write.
- Assert rst_n low during the WRITE cycle of an RMW -> mem_r_wn=1 immediately, target word keeps its old value, resp_valid=0, req_ready=1 after release.
